controle_envase: RTL and testbench

CONTROLE_ENVASE -- requirements
Module: controle_envase

---
 rtl/esteira_pkg.sv | 21 ++
 rtl/temporizador.sv | 29 ++
 rtl/controle_envase.sv | 134 +++++++++++++
 tb/tb_controle_envase.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/esteira_pkg.sv
// rtl/esteira_pkg.sv - state encodings and constants for the bottling line (optional timeout: TIMEOUT_ESTEIRA_EN)
package esteira_pkg;

    typedef enum logic [2:0] {
        PARADO    = 3'd0,
        MOVENDO   = 3'd1,
        ENCHENDO  = 3'd2,
        VEDANDO   = 3'd3,
        LIBERANDO = 3'd4,
        FALHA     = 3'd5
    } estado_t;

    localparam int T_VEDAR_PADRAO     = 4;
    localparam int T_TIMEOUT_PADRAO   = 1000;
    localparam int GARRAFAS_POR_DUZIA = 12;

    function automatic logic [7:0] incrementa_saturado(input logic [7:0] valor);
        return (valor == 8'hFF) ? valor : valor + 8'd1;
    endfunction

endpackage

// File: rtl/temporizador.sv
// rtl/temporizador.sv - loadable down-counter with clear and zero flag
// Counting stops at zero; load takes priority over decrement.
module temporizador #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/controle_envase.sv
// rtl/controle_envase.sv - fill/cap/release sequencer with bottle and dozen counters (optional timeout: TIMEOUT_ESTEIRA_EN)
module controle_envase
    import esteira_pkg::*;
#(
    parameter int T_VEDAR   = T_VEDAR_PADRAO,
    parameter int T_TIMEOUT = T_TIMEOUT_PADRAO
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Liga,
    input  logic       Desliga,
    input  logic       Sensor_Garrafa,
    input  logic       Sensor_Nivel,
    output logic       Comando_Mover_Esteira,
    output logic       Valvula_Enchimento,
    output logic       Vedador,
    output logic [3:0] Contador_Garrafas,
    output logic [7:0] Contador_Duzias,
    output logic       Duzia_Completa,
    output logic       Alarme
);

    estado_t    estado;
    estado_t    proximo;
    logic       troca;
    logic       conta;
    logic       vedar_zero;
    logic       timeout;
    logic [3:0] garrafas;
    logic [7:0] duzias;
    logic       duzia_pulso;

    assign troca = (proximo != estado);

    // Dwell timer is reloaded on entry so the capper runs exactly T_VEDAR cycles.
    temporizador #(.W(8)) u_vedar (
        .clk        (clk),
        .Reset      (Reset),
        .clear      (troca && (proximo != VEDANDO)),
        .load       (troca && (proximo == VEDANDO)),
        .load_value (8'(T_VEDAR - 1)),
        .enable     (estado == VEDANDO),
        .zero       (vedar_zero)
    );

`ifdef TIMEOUT_ESTEIRA_EN
    logic vigiado;
    logic entra_vigiado;
    logic timeout_zero;

    assign vigiado       = (estado == MOVENDO) || (estado == ENCHENDO);
    assign entra_vigiado = (proximo == MOVENDO) || (proximo == ENCHENDO);

    temporizador #(.W(16)) u_timeout (
        .clk        (clk),
        .Reset      (Reset),
        .clear      (troca && !entra_vigiado),
        .load       (troca && entra_vigiado),
        .load_value (16'(T_TIMEOUT - 1)),
        .enable     (vigiado),
        .zero       (timeout_zero)
    );

    assign timeout = vigiado && timeout_zero;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        proximo = estado;
        conta   = 1'b0;
        case (estado)
            PARADO: begin
                if (Liga && !Desliga) proximo = MOVENDO;
            end
            MOVENDO: begin
                if (Desliga)             proximo = PARADO;
                else if (Sensor_Garrafa) proximo = ENCHENDO;
                else if (timeout)        proximo = FALHA;
            end
            ENCHENDO: begin
                if (Sensor_Nivel)  proximo = VEDANDO;
                else if (timeout)  proximo = FALHA;
            end
            VEDANDO: begin
                if (vedar_zero) begin
                    proximo = LIBERANDO;
                    conta   = 1'b1;
                end
            end
            LIBERANDO: begin
                // Wait for the bottle to leave so it is never counted twice.
                if (!Sensor_Garrafa) proximo = MOVENDO;
            end
            FALHA:   proximo = FALHA;
            default: proximo = PARADO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            estado      <= PARADO;
            garrafas    <= 4'd0;
            duzias      <= 8'd0;
            duzia_pulso <= 1'b0;
        end else begin
            estado      <= proximo;
            duzia_pulso <= 1'b0;
            if (conta) begin
                if (garrafas == 4'(GARRAFAS_POR_DUZIA - 1)) begin
                    garrafas    <= 4'd0;
                    duzia_pulso <= 1'b1;
                    duzias      <= incrementa_saturado(duzias);
                end else begin
                    garrafas <= garrafas + 4'd1;
                end
            end
        end
    end

    assign Comando_Mover_Esteira = (estado == MOVENDO) || (estado == LIBERANDO);
    assign Valvula_Enchimento    = (estado == ENCHENDO);
    assign Vedador               = (estado == VEDANDO);
    assign Contador_Garrafas     = garrafas;
    assign Contador_Duzias       = duzias;
    assign Duzia_Completa        = duzia_pulso;

`ifdef TIMEOUT_ESTEIRA_EN
    assign Alarme = (estado == FALHA);
`else
    assign Alarme = 1'b0;
`endif

endmodule

// File: tb/tb_controle_envase.sv
// tb/tb_controle_envase.sv - scoreboard bench for controle_envase (optional timeout: TIMEOUT_ESTEIRA_EN)
module tb_controle_envase;

    localparam int TB_T_VEDAR   = 4;
    localparam int TB_T_TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Liga = 1'b0;
    logic       Desliga = 1'b0;
    logic       Sensor_Garrafa = 1'b0;
    logic       Sensor_Nivel = 1'b0;
    logic       Comando_Mover_Esteira;
    logic       Valvula_Enchimento;
    logic       Vedador;
    logic [3:0] Contador_Garrafas;
    logic [7:0] Contador_Duzias;
    logic       Duzia_Completa;
    logic       Alarme;

    controle_envase #(
        .T_VEDAR   (TB_T_VEDAR),
        .T_TIMEOUT (TB_T_TIMEOUT)
    ) dut (
        .clk                   (clk),
        .Reset                 (Reset),
        .Liga                  (Liga),
        .Desliga               (Desliga),
        .Sensor_Garrafa        (Sensor_Garrafa),
        .Sensor_Nivel          (Sensor_Nivel),
        .Comando_Mover_Esteira (Comando_Mover_Esteira),
        .Valvula_Enchimento    (Valvula_Enchimento),
        .Vedador               (Vedador),
        .Contador_Garrafas     (Contador_Garrafas),
        .Contador_Duzias       (Contador_Duzias),
        .Duzia_Completa        (Duzia_Completa),
        .Alarme                (Alarme)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0..5 = stopped, moving, filling, capping, releasing, fault.
    int m_fase  = 0;
    int m_idade = 0;
    int m_garr  = 0;
    int m_duz   = 0;
    bit m_pulso = 0;

    logic [16:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    bit driver_done = 0;

    task automatic model_step(input bit rst, input bit liga, input bit desl, input bit sg, input bit sn);
        int nxt;
        bit contou;
        contou  = 0;
        m_pulso = 0;
        if (rst) begin
            m_fase = 0; m_idade = 0; m_garr = 0; m_duz = 0;
            return;
        end
        m_idade = m_idade + 1;
        nxt = m_fase;
        case (m_fase)
            0: if (liga && !desl) nxt = 1;
            1: if (desl) nxt = 0; else if (sg) nxt = 2;
            2: if (sn) nxt = 3;
            3: if (m_idade == TB_T_VEDAR) begin nxt = 4; contou = 1; end
            4: if (!sg) nxt = 1;
            default: nxt = m_fase;
        endcase
`ifdef TIMEOUT_ESTEIRA_EN
        if ((m_fase == 1 || m_fase == 2) && nxt == m_fase && m_idade >= TB_T_TIMEOUT) nxt = 5;
`endif
        if (contou) begin
            m_garr = m_garr + 1;
            if (m_garr == 12) begin
                m_garr  = 0;
                m_pulso = 1;
                if (m_duz < 255) m_duz = m_duz + 1;
            end
        end
        if (nxt != m_fase) m_idade = 0;
        m_fase = nxt;
    endtask

    function automatic logic [16:0] model_out();
        logic [16:0] v;
        v = {(m_fase == 1 || m_fase == 4), (m_fase == 2), (m_fase == 3), (m_fase == 5),
             4'(m_garr), 8'(m_duz), m_pulso};
        return v;
    endfunction

    task automatic apply(input bit rst, input bit liga, input bit desl, input bit sg, input bit sn);
        @(negedge clk);
        Reset = rst; Liga = liga; Desliga = desl; Sensor_Garrafa = sg; Sensor_Nivel = sn;
        model_step(rst, liga, desl, sg, sn);
        exp_q.push_back(model_out());
    endtask

    function automatic bit r();
        return 1'($urandom_range(0, 1));
    endfunction

    // Full bottle starting from the moving phase; inputs the controller ignores are randomized.
    task automatic bottle();
        apply(0, r(), 0, 1, r());
        apply(0, r(), r(), 1, 1);
        repeat (TB_T_VEDAR) apply(0, r(), r(), r(), r());
        apply(0, r(), r(), 0, r());
    endtask

    initial begin : monitor
        logic [16:0] e;
        logic [16:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {Comando_Mover_Esteira, Valvula_Enchimento, Vedador, Alarme,
                     Contador_Garrafas, Contador_Duzias, Duzia_Completa};
                vectors = vectors + 1;
                if (a !== e) begin
                    miscompares = miscompares + 1;
                    $display("FAIL outputs vec %0d: got cmd/val/ved/alm=%b%b%b%b garr=%0d duz=%0d pulse=%b, expected %b%b%b%b garr=%0d duz=%0d pulse=%b",
                             vectors, a[16], a[15], a[14], a[13], a[12:9], a[8:1], a[0],
                             e[16], e[15], e[14], e[13], e[12:9], e[8:1], e[0]);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d required completion", vectors);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        apply(1, 0, 0, 0, 0);
        apply(1, 1, 0, 1, 1);

        // Reset in the second capping cycle: nothing counted.
        apply(0, 1, 0, 0, 0);
        apply(0, 0, 0, 1, 0);
        apply(0, 0, 0, 1, 1);
        apply(0, 0, 0, 1, 0);
        apply(1, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 0);

        // Start and stop together: stop wins.
        repeat (3) apply(0, 1, 1, 0, 0);

        // Normal bottle.
        apply(0, 1, 0, 0, 0);
        bottle();

        // Bottle held at the station while releasing.
        apply(0, 0, 0, 1, 0);
        apply(0, 0, 0, 1, 1);
        repeat (TB_T_VEDAR) apply(0, 0, 0, 1, 0);
        repeat (10) apply(0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 0);

        // Stop during filling: fill and cap finish, then stop once moving.
        apply(0, 0, 0, 1, 0);
        apply(0, 0, 1, 1, 0);
        apply(0, 0, 1, 1, 1);
        repeat (TB_T_VEDAR) apply(0, 0, 1, 1, 0);
        apply(0, 0, 1, 0, 0);
        apply(0, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), r(), ($urandom_range(0, 2) == 0));
        end

        // Conveyor with no bottle arriving; faults only with the timeout feature.
        apply(1, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0);
        repeat (TB_T_TIMEOUT + 5) apply(0, r(), 0, 0, 0);
        repeat (3) apply(0, 1, 0, 0, 0);
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);

        // Dozens up to and past saturation.
        apply(1, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0);
        for (int b = 0; b < 256 * 12 + 14; b++) bottle();
        apply(0, 0, 1, 0, 0);
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
        end
        driver_done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
